// File: rtl/base_vrotr_if.sv
// Valid/ready stream bundle for base_vrotr: input word plus rotate amount in,
// rotated word out. Bit vectors are big-endian, index 0 is the MSB.
interface base_vrotr_if #(
  parameter int width = 8
);
  localparam int aw = (width > 1) ? $clog2(width) : 1;

  logic             i_v;
  logic             i_r;
  logic [0:width-1] i_d;
  logic [0:aw-1]    i_amt;
  logic             o_v;
  logic             o_r;
  logic [0:width-1] o_d;

  modport master (output i_v, i_d, i_amt, o_r, input i_r, o_v, o_d);
  modport slave  (input i_v, i_d, i_amt, o_r, output i_r, o_v, o_d);
endinterface

// File: rtl/base_vrotr.sv
// Pipelined variable-amount right rotator. Stage k rotates right by 2^k when
// bit k of the (mod width) amount is set; each stage has its own valid bit and
// accepts whenever it is empty or the stage below it can move.
module base_vrotr #(
  parameter int width = 8
) (
  input logic         clk,
  input logic         reset,
  base_vrotr_if.slave bus
);
  localparam int aw     = (width > 1) ? $clog2(width) : 1;
  localparam int stages = aw;

  // Numeric right rotate: bit 0 is the LSB, i.e. the highest big-endian index.
  function automatic logic [width-1:0] rotr(input logic [width-1:0] x, input int unsigned n);
    if (n == 0) return x;
    return (x >> n) | (x << (width - n));
  endfunction

  logic [width-1:0]  din;
  logic [aw-1:0]     amt_in;
  logic [aw-1:0]     eff;

  logic [stages-1:0] v_q;
  logic [stages-1:0] v_d;
  logic [stages-1:0] adv;
  logic [width-1:0]  d_q [stages];
  logic [width-1:0]  d_d [stages];
  logic [aw-1:0]     a_q [stages];
  logic [aw-1:0]     a_d [stages];

  assign din    = bus.i_d;
  assign amt_in = bus.i_amt;
  assign eff    = aw'(32'(amt_in) % 32'(width));

  // Per-stage upstream source and the data it would load after this stage's step.
  for (genvar k = 0; k < stages; k++) begin : g_stage
    localparam int unsigned Step = (1 << k) % width;
    if (k == 0) begin : g_head
      assign v_d[k] = bus.i_v;
      assign a_d[k] = eff;
      assign d_d[k] = eff[k] ? rotr(din, Step) : din;
    end else begin : g_body
      assign v_d[k] = v_q[k-1];
      assign a_d[k] = a_q[k-1];
      assign d_d[k] = a_q[k-1][k] ? rotr(d_q[k-1], Step) : d_q[k-1];
    end
  end

  // Advance chain: a stage moves if it is empty or every stage below can move.
  // Built as a running OR from the output end so no signal feeds back on itself.
  always_comb begin
    logic acc;
    acc = bus.o_r;
    adv = '0;
    for (int unsigned n = 0; n < stages; n++) begin
      acc = acc | ~v_q[stages-1-n];
      adv[stages-1-n] = acc;
    end
  end

  // Stage registers: valid follows upstream on advance; payload moves only with a valid word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int unsigned k = 0; k < stages; k++) begin
        d_q[k] <= '0;
        a_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < stages; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_d[k];
          if (v_d[k]) begin
            d_q[k] <= d_d[k];
            a_q[k] <= a_d[k];
          end
        end
      end
    end
  end

  assign bus.i_r = adv[0] & ~reset;
  assign bus.o_v = v_q[stages-1];
  assign bus.o_d = d_q[stages-1];
endmodule
